// File: rtl/fcims_pkg.sv
// Shared types for the FCIMS transaction sequencer: result codes, FSM states
// and the default datapath widths.
package fcims_pkg;

    localparam int CNT_W_DEF    = 4;
    localparam int UPRICE_W_DEF = 4;
    localparam int TOTAL_W_DEF  = CNT_W_DEF + UPRICE_W_DEF;

    typedef enum logic [1:0] {
        ST_OK       = 2'b00,
        ST_NO_STOCK = 2'b01,
        ST_NO_FUNDS = 2'b10,
        ST_OVERFLOW = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_MUL   = 2'b01,
        S_CHECK = 2'b10,
        S_RESP  = 2'b11
    } state_e;

endpackage

// File: rtl/fcims_txn_sequencer_if.sv
// Request/response/status bundle between the FCIMS stations (master) and the
// transaction sequencer (slave).
interface fcims_txn_sequencer_if #(
    parameter int CNT_W    = fcims_pkg::CNT_W_DEF,
    parameter int UPRICE_W = fcims_pkg::UPRICE_W_DEF,
    parameter int TOTAL_W  = fcims_pkg::TOTAL_W_DEF
);
    logic                          init_valid;
    logic [CNT_W-1:0]              init_count;
    logic [TOTAL_W-1:0]            init_total;
    logic [1:0]                    req_valid;
    logic [1:0]                    req_op;
    logic [1:0][CNT_W-1:0]         req_ncell;
    logic [1:0][UPRICE_W-1:0]      req_uprice;
    logic [1:0]                    req_ready;
    logic                          resp_valid;
    logic                          resp_port;
    logic [1:0]                    resp_status;
    logic [TOTAL_W-1:0]            resp_price;
    logic [CNT_W-1:0]              count;
    logic [TOTAL_W-1:0]            total;
    logic                          empty;
    logic                          busy;

    modport master (
        output init_valid, init_count, init_total,
        output req_valid, req_op, req_ncell, req_uprice,
        input  req_ready, resp_valid, resp_port, resp_status, resp_price,
        input  count, total, empty, busy
    );

    modport slave (
        input  init_valid, init_count, init_total,
        input  req_valid, req_op, req_ncell, req_uprice,
        output req_ready, resp_valid, resp_port, resp_status, resp_price,
        output count, total, empty, busy
    );

endinterface

// File: rtl/fcims_rr_arbiter2.sv
// Two-port round-robin arbiter; the pointer remembers the last granted port
// and moves only when a grant is actually taken.
module fcims_rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o,
    output logic       ptr_o
);

    logic last_q, last_d;

    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
        if (advance_i && (gnt_o != 2'b00)) begin
            last_d = gnt_o[1];
        end
    end

    // Reset to "port 1 was last" so port 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign ptr_o = last_q;

endmodule

// File: rtl/fcims_txn_sequencer.sv
// Stock/cash transaction sequencer: arbitrates two stations and applies each
// sale/restock through a shared multiply -> check -> commit datapath.
//
//   state   | meaning
//   IDLE    | accept init load or grant one pending request
//   MUL     | form price = ncell * uprice
//   CHECK   | classify, commit count/total when OK
//   RESP    | one-cycle response pulse
module fcims_txn_sequencer
    import fcims_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int UPRICE_W = UPRICE_W_DEF,
    parameter int TOTAL_W  = TOTAL_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    fcims_txn_sequencer_if.slave  bus
);

    state_e                state_q, state_d;
    status_e               status_q, status_d, chk_status;
    logic                  op_q, op_d;
    logic                  port_q, port_d;
    logic [CNT_W-1:0]      ncell_q, ncell_d;
    logic [UPRICE_W-1:0]   uprice_q, uprice_d;
    logic [TOTAL_W-1:0]    price_q, price_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [TOTAL_W-1:0]    total_q, total_d;
    logic [CNT_W:0]        cnt_add;
    logic [TOTAL_W:0]      tot_add;
    logic [1:0]            arb_req, gnt;
    logic                  rr_ptr_unused;

    // Requests are only visible to the arbiter when a grant can really be taken.
    assign arb_req = (state_q == S_IDLE && !bus.init_valid && !reset) ? bus.req_valid : 2'b00;

    fcims_rr_arbiter2 u_arb (
        .clk       (clk),
        .rst       (reset),
        .req_i     (arb_req),
        .advance_i (|arb_req),
        .gnt_o     (gnt),
        .ptr_o     (rr_ptr_unused)
    );

    always_comb begin
        cnt_add    = {1'b0, count_q} + {1'b0, ncell_q};
        tot_add    = {1'b0, total_q} + {1'b0, price_q};
        chk_status = ST_OK;
        if (op_q) begin
            if (ncell_q > count_q)         chk_status = ST_NO_STOCK;
            else if (tot_add[TOTAL_W])     chk_status = ST_OVERFLOW;
        end else begin
            if (price_q > total_q)         chk_status = ST_NO_FUNDS;
            else if (cnt_add[CNT_W])       chk_status = ST_OVERFLOW;
        end
    end

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        op_d     = op_q;
        port_d   = port_q;
        ncell_d  = ncell_q;
        uprice_d = uprice_q;
        price_d  = price_q;
        count_d  = count_q;
        total_d  = total_q;
        case (state_q)
            S_IDLE: begin
                if (bus.init_valid) begin
                    count_d = bus.init_count;
                    total_d = bus.init_total;
                end else if (gnt != 2'b00) begin
                    port_d   = gnt[1];
                    op_d     = bus.req_op[gnt[1]];
                    ncell_d  = bus.req_ncell[gnt[1]];
                    uprice_d = bus.req_uprice[gnt[1]];
                    state_d  = S_MUL;
                end
            end
            S_MUL: begin
                price_d = TOTAL_W'(ncell_q) * TOTAL_W'(uprice_q);
                state_d = S_CHECK;
            end
            S_CHECK: begin
                status_d = chk_status;
                if (chk_status == ST_OK) begin
                    if (op_q) begin
                        count_d = count_q - ncell_q;
                        total_d = tot_add[TOTAL_W-1:0];
                    end else begin
                        count_d = cnt_add[CNT_W-1:0];
                        total_d = total_q - price_q;
                    end
                end
                state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            status_q <= ST_OK;
            op_q     <= 1'b0;
            port_q   <= 1'b0;
            ncell_q  <= '0;
            uprice_q <= '0;
            price_q  <= '0;
            count_q  <= '0;
            total_q  <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            op_q     <= op_d;
            port_q   <= port_d;
            ncell_q  <= ncell_d;
            uprice_q <= uprice_d;
            price_q  <= price_d;
            count_q  <= count_d;
            total_q  <= total_d;
        end
    end

    assign bus.req_ready   = gnt;
    assign bus.resp_valid  = (state_q == S_RESP);
    assign bus.resp_port   = port_q;
    assign bus.resp_status = status_q;
    assign bus.resp_price  = price_q;
    assign bus.count       = count_q;
    assign bus.total       = total_q;
    assign bus.empty       = (count_q == '0);
    assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_fcims_txn_sequencer.sv
// Scoreboard bench for fcims_txn_sequencer: a reference model predicts each
// granted transaction and the response monitor checks it against the DUT.
module tb_fcims_txn_sequencer;

    localparam int CNT_W    = 4;
    localparam int UPRICE_W = 4;
    localparam int TOTAL_W  = 8;
    localparam int MAX_CNT  = (1 << CNT_W) - 1;
    localparam int MAX_TOT  = (1 << TOTAL_W) - 1;

    typedef struct {
        int port;
        int status;
        int price;
        int cnt;
        int tot;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   model_cnt = 0;
    int   model_tot = 0;
    exp_t sb_q[$];
    int   gnt_port_log[$];
    int   gnt_cyc_log[$];

    int   m_op, m_ncell, m_uprice, m_price, m_st;
    exp_t m_e, r_e;

    fcims_txn_sequencer_if #(.CNT_W(CNT_W), .UPRICE_W(UPRICE_W), .TOTAL_W(TOTAL_W)) bus ();

    fcims_txn_sequencer #(.CNT_W(CNT_W), .UPRICE_W(UPRICE_W), .TOTAL_W(TOTAL_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Grant side: predict the outcome; response side: compare.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.req_ready != 2'b00)
                check_val("ready_onehot", $countones(bus.req_ready), 1);
            for (int i = 0; i < 2; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    m_op     = int'(bus.req_op[i]);
                    m_ncell  = int'(bus.req_ncell[i]);
                    m_uprice = int'(bus.req_uprice[i]);
                    m_price  = m_ncell * m_uprice;
                    if (m_op == 1) begin
                        if (m_ncell > model_cnt)                m_st = 1;
                        else if (model_tot + m_price > MAX_TOT) m_st = 3;
                        else                                     m_st = 0;
                    end else begin
                        if (m_price > model_tot)                m_st = 2;
                        else if (model_cnt + m_ncell > MAX_CNT) m_st = 3;
                        else                                     m_st = 0;
                    end
                    if (m_st == 0) begin
                        model_cnt = (m_op == 1) ? model_cnt - m_ncell : model_cnt + m_ncell;
                        model_tot = (m_op == 1) ? model_tot + m_price : model_tot - m_price;
                    end
                    m_e.port   = i;
                    m_e.status = m_st;
                    m_e.price  = m_price;
                    m_e.cnt    = model_cnt;
                    m_e.tot    = model_tot;
                    m_e.cyc    = cyc + 3;
                    sb_q.push_back(m_e);
                    gnt_port_log.push_back(i);
                    gnt_cyc_log.push_back(cyc);
                end
            end
            if (bus.resp_valid) begin
                if (sb_q.size() == 0) begin
                    check_val("resp_unexpected", 1, 0);
                end else begin
                    r_e = sb_q.pop_front();
                    check_val("resp_latency", cyc, r_e.cyc);
                    check_val("resp_port", bus.resp_port, r_e.port);
                    check_val("resp_status", bus.resp_status, r_e.status);
                    check_val("resp_price", bus.resp_price, r_e.price);
                    check_val("resp_count", bus.count, r_e.cnt);
                    check_val("resp_total", bus.total, r_e.tot);
                    check_val("resp_empty", bus.empty, (r_e.cnt == 0) ? 1 : 0);
                end
            end
        end
    end

    task automatic reset_dut();
        reset = 1'b1;
        bus.init_valid = 1'b0;
        bus.init_count = '0;
        bus.init_total = '0;
        bus.req_valid  = 2'b11;
        bus.req_op     = '0;
        bus.req_ncell  = '0;
        bus.req_uprice = '0;
        @(posedge clk); #1;
        check_val("rst_count", bus.count, 0);
        check_val("rst_total", bus.total, 0);
        check_val("rst_empty", bus.empty, 1);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_ready", bus.req_ready, 0);
        check_val("rst_resp_valid", bus.resp_valid, 0);
        check_val("rst_resp_port", bus.resp_port, 0);
        check_val("rst_resp_status", bus.resp_status, 0);
        check_val("rst_resp_price", bus.resp_price, 0);
        bus.req_valid = 2'b00;
        @(posedge clk); #1;
        reset = 1'b0;
        model_cnt = 0;
        model_tot = 0;
        sb_q.delete();
    endtask

    task automatic init_load(input int c, input int t);
        bus.init_valid = 1'b1;
        bus.init_count = CNT_W'(c);
        bus.init_total = TOTAL_W'(t);
        @(posedge clk); #1;
        bus.init_valid = 1'b0;
        model_cnt = c;
        model_tot = t;
        check_val("init_count", bus.count, c);
        check_val("init_total", bus.total, t);
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (sb_q.size() != 0 && w < 12) begin
            @(posedge clk); #1;
            w++;
        end
        check_val("resp_timeout", sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic do_txn(input int port, input int op, input int ncell, input int uprice,
                          input bit poke_init);
        int  w;
        bit  got;
        bus.req_valid[port]  = 1'b1;
        bus.req_op[port]     = op[0];
        bus.req_ncell[port]  = CNT_W'(ncell);
        bus.req_uprice[port] = UPRICE_W'(uprice);
        w   = 0;
        got = 1'b0;
        while (!got && w < 20) begin
            @(negedge clk);
            if (bus.req_ready[port]) got = 1'b1;
            else                     w++;
        end
        check_val("grant_wait", w, 0);
        @(posedge clk); #1;
        bus.req_valid[port] = 1'b0;
        if (poke_init) begin
            bus.init_valid = 1'b1;
            bus.init_count = CNT_W'(9);
            bus.init_total = TOTAL_W'(99);
            @(posedge clk); #1;
            bus.init_valid = 1'b0;
        end
        wait_drain();
    endtask

    initial begin
        int n;
        reset_dut();

        init_load(10, 20);
        do_txn(0, 1, 3, 5, 1'b0);

        init_load(2, 50);
        do_txn(1, 1, 3, 1, 1'b0);

        init_load(0, 10);
        do_txn(0, 0, 4, 3, 1'b0);
        do_txn(0, 0, 2, 5, 1'b0);
        init_load(15, 100);
        do_txn(1, 0, 1, 1, 1'b0);
        init_load(5, 250);
        do_txn(0, 1, 2, 4, 1'b0);
        init_load(2, 250);
        do_txn(1, 1, 3, 5, 1'b0);

        init_load(5, 0);
        do_txn(0, 1, 5, 2, 1'b0);
        do_txn(1, 1, 0, 7, 1'b0);

        init_load(4, 40);
        do_txn(0, 0, 1, 2, 1'b1);
        check_val("init_ignored_count", bus.count, 5);
        check_val("init_ignored_total", bus.total, 38);

        // Abort a sale while it sits in CHECK.
        init_load(10, 20);
        bus.req_valid[0]  = 1'b1;
        bus.req_op[0]     = 1'b1;
        bus.req_ncell[0]  = CNT_W'(3);
        bus.req_uprice[0] = UPRICE_W'(5);
        @(negedge clk);
        check_val("abort_grant", bus.req_ready[0], 1);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_val("abort_resp_valid", bus.resp_valid, 0);
        check_val("abort_count", bus.count, 0);
        check_val("abort_total", bus.total, 0);
        check_val("abort_busy", bus.busy, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        sb_q.delete();
        model_cnt = 0;
        model_tot = 0;
        @(negedge clk);
        check_val("abort_no_resp", bus.resp_valid, 0);
        @(posedge clk); #1;
        do_txn(1, 1, 0, 3, 1'b0);

        // Both stations hold requests continuously.
        reset_dut();
        init_load(0, 200);
        gnt_port_log.delete();
        gnt_cyc_log.delete();
        bus.req_op     = 2'b00;
        bus.req_ncell  = {CNT_W'(1), CNT_W'(1)};
        bus.req_uprice = {UPRICE_W'(1), UPRICE_W'(1)};
        bus.req_valid  = 2'b11;
        n = 0;
        while (gnt_port_log.size() < 4 && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        wait_drain();
        check_val("rr_grants", gnt_port_log.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < gnt_port_log.size()) check_val("rr_port", gnt_port_log[i], i % 2);
        for (int i = 1; i < 4; i++)
            if (i < gnt_cyc_log.size()) check_val("rr_spacing", gnt_cyc_log[i] - gnt_cyc_log[i-1], 4);
        check_val("rr_count", bus.count, 4);
        check_val("rr_total", bus.total, 196);

        check_val("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fcims_txn_sequencer.md
# fcims_txn_sequencer

Registered transaction sequencer for the FCIMS inventory/price datapath. Holds the stock count and the running cash total in state. Arbitrates round-robin between two requester ports (e.g. two checkout/restock stations), then applies each accepted transaction through a multi-cycle compute → check → commit sequence. Turns the combinational add/subtract, multiply and compare datapath into a shared, handshaked resource.

## Interface
Parameters:
- CNT_W, 4, stock count and ncell width
- UPRICE_W, 4, unit price width
- TOTAL_W, 8, cash total and price width; must equal CNT_W+UPRICE_W

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- init_valid  in  1  load count/total; sampled only in IDLE
- init_count  in  CNT_W  count load value
- init_total  in  TOTAL_W  total load value
- req_valid  in  2  per-port request valid
- req_op  in  2  per-port op: 1 = sale (count−, total+), 0 = restock (count+, total−)
- req_ncell  in  2×CNT_W  per-port cell quantity
- req_uprice  in  2×UPRICE_W  per-port unit price
- req_ready  out  2  one-hot grant; handshake completes on valid&ready
- resp_valid  out  1  one-cycle result pulse
- resp_port  out  1  port index of the completed transaction
- resp_status  out  2  result code
- resp_price  out  TOTAL_W  ncell×uprice for the transaction
- count  out  CNT_W  current stock
- total  out  TOTAL_W  current cash total
- empty  out  1  count == 0
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, MUL, CHECK, RESP.
- **IDLE**
  - init_valid has priority: load count/total; stay in IDLE; req_ready = 0 that cycle.
  - Otherwise, if any req_valid: grant one port via req_ready, latch op/ncell/uprice/port, go to MUL.
- **MUL:** price_r ← ncell×uprice, full TOTAL_W product with no truncation; go to CHECK.
- **CHECK:** compute status; on OK, write count/total at the end of the cycle; go to RESP.
- **RESP:** resp_valid = 1; resp_port, resp_status and resp_price hold. Return to IDLE.
- Status codes:
  - 00 OK
  - 01 NO_STOCK: sale with ncell > count
  - 10 NO_FUNDS: restock with price > total
  - 11 OVERFLOW: restock with count+ncell > 2^CNT_W−1, or sale with total+price > 2^TOTAL_W−1
  - Precedence: NO_STOCK/NO_FUNDS over OVERFLOW. Any non-OK status leaves count/total unchanged.
- ncell = 0 → OK, price 0, no state change.
- Exact equality is OK: sale with ncell == count → count 0, empty = 1; restock with price == total → total 0.
- Arbitration: 2-port round-robin. The last-granted pointer updates only on a grant. With both ports valid, the port not granted last wins. After reset, port 0 has priority.
- Requests not granted stay pending; requesters must hold valid and payload until ready.
- init_valid outside IDLE is ignored, with no queuing.

## Timing
- Request accepted at the edge ending cycle N (IDLE).
- MUL is cycle N+1, CHECK is N+2, RESP is N+3: resp_valid high during N+3, and count/total already show the new values in N+3.
- Next grant possible in N+4. Peak throughput is 1 transaction per 4 cycles.
- init load is visible on count/total the cycle after the init_valid edge.
- req_ready is combinational from state, req_valid and the pointer; high only in IDLE with init_valid = 0.
- Reset values:
  - count = 0, total = 0, empty = 1, busy = 0
  - req_ready = 0, resp_valid = 0, resp_port = 0, resp_status = 00, resp_price = 0
  - State IDLE, pointer favours port 0.
- Reset asserted mid-transaction: abort immediately. No commit, no resp_valid, all outputs go to reset values.
- Reset released: first grant possible in the first cycle after deassertion.

## Structure
- fcims_pkg holds: status codes (ST_OK, ST_NO_STOCK, ST_NO_FUNDS, ST_OVERFLOW), the FSM state enum, and default widths.
- One sub-module: fcims_rr_arbiter2.
  - Inputs: req[1:0], advance.
  - Outputs: one-hot gnt, plus pointer register.
  - Clocked on clk with the same asynchronous reset.
- The multiply, compare and add/sub logic is inline in the sequencer.

## Test plan
- **Init then sale:** init count = 10, total = 20; port 0 sale ncell = 3, uprice = 5 → resp at N+3 with status 00, price 15; count = 7, total = 35.
- **Insufficient stock:** count = 2; sale ncell = 3 → status 01; count/total unchanged; empty stays 0.
- **Funds checks:** total = 10; restock ncell = 4, uprice = 3 (price 12) → status 10. Restock ncell = 2, uprice = 5 → OK with total = 0. count = 15 plus restock ncell = 1 → status 11.
- **Round-robin:** both ports valid continuously after reset → grants alternate 0, 1, 0, 1, spaced 4 cycles apart; resp_port matches each grant.
- **Exact sale and zero quantity:** sale ncell == count (5) → count 0, empty = 1. Then ncell = 0 → status 00, nothing changes.
- **Reset and ignored init:** reset asserted during CHECK → no resp_valid, count = 0, total = 0, busy = 0. init_valid asserted during MUL is ignored.
